// File: rtl/avalon_input_pio_pkg.sv
// Shared constants for the avalon_input_pio peripheral: bus width and register word addresses.
package avalon_input_pio_pkg;
  localparam int AVL_DW = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EDGESEL = 2'd3;
endpackage

// File: rtl/avalon_input_pio_debounce_bit.sv
// One input bit: 2-FF synchronizer followed by a stability counter that gates updates of deb.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  // deb only follows sync after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb = r_deb;
endmodule

// File: rtl/avalon_input_pio.sv
// Avalon-MM input PIO: debounced switch/key inputs, edge capture with polarity select,
// maskable level interrupt and fixed one-cycle read latency.
module avalon_input_pio
  import avalon_input_pio_pkg::*;
#(
  parameter int N_IN            = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_IN-1:0]   raw_in,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [1:0]        AVL_ADDR,
  input  logic [AVL_DW-1:0] AVL_WRITEDATA,
  output logic [AVL_DW-1:0] AVL_READDATA,
  output logic              IRQ
);
  logic [N_IN-1:0]   w_deb;
  logic [N_IN-1:0]   w_rise;
  logic [N_IN-1:0]   w_fall;
  logic [N_IN-1:0]   w_hit;
  logic [N_IN-1:0]   w_wdata;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [AVL_DW-1:0] w_rd_mux;
  logic              w_unused_wdata;

  logic [N_IN-1:0]   r_prev;
  logic [N_IN-1:0]   r_irqmask;
  logic [N_IN-1:0]   r_edgecap;
  logic [N_IN-1:0]   r_edgesel;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .Clk   (Clk),
      .Reset (Reset),
      .i_raw (raw_in[gi]),
      .o_deb (w_deb[gi])
    );
  end

  assign w_wr_en        = AVL_CS & AVL_WRITE;
  assign w_rd_en        = AVL_CS & AVL_READ;
  assign w_wdata        = AVL_WRITEDATA[N_IN-1:0];
  assign w_unused_wdata = ^AVL_WRITEDATA[AVL_DW-1:N_IN];

  assign w_rise = w_deb & ~r_prev;
  assign w_fall = ~w_deb & r_prev;
  assign w_hit  = (r_edgesel & w_rise) | (~r_edgesel & w_fall);

  assign IRQ = |(r_edgecap & r_irqmask);

  always_comb begin
    w_rd_mux = '0;
    case (AVL_ADDR)
      ADDR_DATA:    w_rd_mux[N_IN-1:0] = w_deb;
      ADDR_IRQMASK: w_rd_mux[N_IN-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd_mux[N_IN-1:0] = r_edgecap;
      ADDR_EDGESEL: w_rd_mux[N_IN-1:0] = r_edgesel;
      default:      w_rd_mux = '0;
    endcase
  end

  // The edge OR is applied after the W1C mask so a fresh edge survives a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev       <= '0;
      r_irqmask    <= '0;
      r_edgecap    <= '0;
      r_edgesel    <= '0;
      AVL_READDATA <= '0;
    end else begin
      r_prev       <= w_deb;
      AVL_READDATA <= w_rd_en ? w_rd_mux : '0;
      if (w_wr_en && AVL_ADDR == ADDR_IRQMASK) r_irqmask <= w_wdata;
      if (w_wr_en && AVL_ADDR == ADDR_EDGESEL) r_edgesel <= w_wdata;
      if (w_wr_en && AVL_ADDR == ADDR_EDGECAP) begin
        r_edgecap <= (r_edgecap & ~w_wdata) | w_hit;
      end else begin
        r_edgecap <= r_edgecap | w_hit;
      end
    end
  end
endmodule

// File: tb/tb_avalon_input_pio.sv
// Directed bench for avalon_input_pio with DEBOUNCE_CYCLES = 4; all expected values hand-derived.
module tb_avalon_input_pio;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  raw_in = 10'h3FF;
  logic        AVL_CS = 1'b0;
  logic        AVL_READ = 1'b0;
  logic        AVL_WRITE = 1'b0;
  logic [1:0]  AVL_ADDR = 2'd0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  avalon_input_pio #(
    .N_IN(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .raw_in        (raw_in),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .IRQ           (IRQ)
  );

  always #5 Clk = ~Clk;

  // Every step lands 1 ns after a rising edge, away from the sampling point.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request sampled at the next edge; data returned is what that edge registered.
  task automatic rd(input logic [1:0] a, output logic [31:0] data);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    tick(1);
    data = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = v;
    tick(1);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_WRITEDATA = '0;
  endtask

  // After release at edge r: regs read 0, deb updates at edge r+6 so a read sampled at r+7 sees it.
  task automatic post_reset_seq(input logic [31:0] data_exp, input string tag);
    chk({tag, "_rdata"}, AVL_READDATA, 32'h0);
    chk({tag, "_irq"}, {31'b0, IRQ}, 32'h0);
    rd(2'd1, d); chk({tag, "_irqmask"}, d, 32'h0);
    rd(2'd2, d); chk({tag, "_edgecap"}, d, 32'h0);
    rd(2'd3, d); chk({tag, "_edgesel"}, d, 32'h0);
    for (int j = 4; j <= 6; j++) begin
      rd(2'd0, d); chk({tag, "_data_early"}, d, 32'h0);
    end
    rd(2'd0, d); chk({tag, "_data_r7"}, d, data_exp);
    tick(2);
    rd(2'd2, d); chk({tag, "_edgecap_after"}, d, 32'h0);
  endtask

  initial begin
    // Reset with all pins high
    tick(2);
    Reset = 1'b0;
    post_reset_seq(32'h3FF, "reset");

    // Switches low: falling edges captured with EDGESEL = 0
    raw_in = 10'h300;
    tick(10);
    rd(2'd2, d); chk("fall_cap", d, 32'h0FF);
    chk("fall_cap_irq", {31'b0, IRQ}, 32'h0);
    wr(2'd2, 32'h3FF);
    rd(2'd2, d); chk("w1c_all", d, 32'h0);

    // Glitch of 3 cycles never reaches deb
    raw_in[3] = 1'b1;
    tick(3);
    raw_in[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      rd(2'd0, d); chk("glitch", d, 32'h300);
    end

    // Valid rise: visible to a read sampled 7 edges after the change
    raw_in[3] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      rd(2'd0, d); chk("rise_data", d, (j < 7) ? 32'h300 : 32'h308);
    end
    tick(4);
    rd(2'd2, d); chk("rise_nocap", d, 32'h0);

    // Capture and interrupt on bit 9 rising
    wr(2'd3, 32'h200);
    wr(2'd1, 32'h200);
    raw_in[9] = 1'b0;
    tick(10);
    rd(2'd2, d); chk("key9_fall_nocap", d, 32'h0);
    raw_in[9] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      rd(2'd0, d); chk("key9_data", d, (j < 7) ? 32'h108 : 32'h308);
      chk("key9_irq", {31'b0, IRQ}, (j == 7) ? 32'h1 : 32'h0);
    end
    rd(2'd2, d); chk("key9_edgecap", d, 32'h200);
    chk("key9_irq_hold", {31'b0, IRQ}, 32'h1);
    wr(2'd2, 32'h200);
    chk("key9_irq_clr", {31'b0, IRQ}, 32'h0);
    rd(2'd2, d); chk("key9_edgecap_clr", d, 32'h0);

    // W1C of bit 8 colliding with a new falling edge of deb[8]
    raw_in[8] = 1'b0;
    tick(10);
    rd(2'd2, d); chk("b8_first_fall", d, 32'h100);
    raw_in[8] = 1'b1;
    tick(10);
    rd(2'd2, d); chk("b8_rise_nocap", d, 32'h100);
    raw_in[8] = 1'b0;
    tick(6);
    wr(2'd2, 32'h100);
    rd(2'd2, d); chk("b8_collision", d, 32'h100);
    wr(2'd2, 32'h100);
    rd(2'd2, d); chk("b8_plain_w1c", d, 32'h0);

    // Back-to-back reads and idle readdata
    wr(2'd1, 32'h2AA);
    wr(2'd3, 32'h155);
    rd(2'd0, d); chk("b2b_data", d, 32'h208);
    rd(2'd1, d); chk("b2b_irqmask", d, 32'h2AA);
    rd(2'd2, d); chk("b2b_edgecap", d, 32'h0);
    rd(2'd3, d); chk("b2b_edgesel", d, 32'h155);
    tick(1);
    chk("idle_rdata", AVL_READDATA, 32'h0);

    // Writes to DATA ignored; upper write bits dropped
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d); chk("data_ro", d, 32'h208);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d); chk("irqmask_upper", d, 32'h3FF);

    // Read and write together: read returns pre-write value
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 2'd1; AVL_WRITEDATA = 32'h0AA;
    tick(1);
    chk("rw_same_rdata", AVL_READDATA, 32'h3FF);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_WRITEDATA = '0;
    rd(2'd1, d); chk("rw_same_written", d, 32'h0AA);

    // Reset while bit 0 is mid-debounce (count 2)
    raw_in[0] = 1'b1;
    tick(4);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    post_reset_seq(32'h209, "mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_input_pio.md
# avalon_input_pio

Avalon-MM slave peripheral that the Nios II master reads to observe the board's switches and push-buttons. It is the responder side of the SoC bus, sitting in fabric between the `SW[7:0]` and `KEY[1:0]` pins and the Nios II data master. Each input bit passes through a synchronizer and a debouncer. The block offers per-bit edge capture with selectable polarity, a maskable level interrupt, and single-cycle-latency register reads.

## Interface
- `N_IN`, 10: number of input bits; `SW` maps to bits [7:0] and `KEY` to bits [9:8].
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before an input is accepted. 500000 is 10 ms at 50 MHz. Minimum value is 2.
- `Clk`  in  1  system clock, 50 MHz; every register updates on its rising edge.
- `Reset`  in  1  synchronous reset, active-high, sampled on the rising edge of `Clk`.
- `raw_in`  in  N_IN  asynchronous pin inputs.
- `AVL_CS`  in  1  chip select.
- `AVL_READ`  in  1  read strobe; only valid together with `AVL_CS`.
- `AVL_WRITE`  in  1  write strobe; only valid together with `AVL_CS`.
- `AVL_ADDR`  in  2  word address.
- `AVL_WRITEDATA`  in  32  write data.
- `AVL_READDATA`  out  32  read data; holds 0 when no read is in progress.
- `IRQ`  out  1  level interrupt, active-high.

## Operation
- **Synchronizer.** Each bit of `raw_in` passes through two flip-flops, producing `sync[i]`.
- **Debouncer (per bit).**
  - Counter `cnt[i]` is cleared while `sync[i] == deb[i]` and increments while they differ.
  - When `sync[i] != deb[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i] <= sync[i]` and `cnt[i] <= 0`.
  - A pulse at `sync` shorter than `DEBOUNCE_CYCLES` cycles never reaches `deb`.
- **Edge capture.** `prev <= deb` every cycle.
  - `rise = deb & ~prev`, `fall = ~deb & prev`.
  - `hit[i] = EDGESEL[i] ? rise[i] : fall[i]`.
  - `EDGECAP[i]` sets on `hit[i]` and stays set until software clears it.
- **Register map** (word addresses):
  - 0 `DATA` (RO): `{0, deb}`.
  - 1 `IRQMASK` (RW): low N_IN bits.
  - 2 `EDGECAP` (R / W1C): writing 1 to a bit clears it.
  - 3 `EDGESEL` (RW): per bit, 1 captures rising edges, 0 captures falling edges.
  - Writes to address 0 are ignored. Unused upper bits read 0.
- **Interrupt.** `IRQ = |(EDGECAP & IRQMASK)`, computed combinationally from registers only.
- **Same-cycle W1C and edge.** If a W1C write and `hit[i]` land on the same bit in the same cycle, the bit ends set (the new edge wins).
- **Reset values.**
  - `sync`, `deb`, `prev`, `cnt`, `IRQMASK`, `EDGECAP`, `EDGESEL`, `AVL_READDATA` all reset to 0.
  - `IRQ` is 0 out of reset.
  - After reset, idle-high `KEY` bits debounce to 1, which is a rising edge. With `EDGESEL = 0` this causes no capture.
- **Reset mid-debounce.** The count is discarded. Debouncing restarts from `deb = 0`.

## Timing
- **Read.** No waitrequest; read latency is 1.
  - With `AVL_CS & AVL_READ` at edge k, `AVL_READDATA` is valid after edge k+1 and returns to 0 after the following edge unless another read is issued.
  - Back-to-back reads are allowed every cycle.
- **Write.** Takes effect at the edge where `AVL_CS & AVL_WRITE` is sampled.
- **Read and write in the same cycle.** Not allowed by the master. If it happens anyway, the write is performed and the read returns the pre-write value.
- **Input latency.** A raw change that stays stable from edge k appears on `sync` after edge k+2 and updates `deb` at edge k+2+DEBOUNCE_CYCLES.
- **Edge and interrupt latency.** `EDGECAP` sets one edge after `deb` changes. `IRQ` rises in that same cycle.
- **Throughput.** One accepted transition per bit per `DEBOUNCE_CYCLES` cycles at most.

## Structure
- Package `avalon_input_pio_pkg` holds:
  - address constants `ADDR_DATA`, `ADDR_IRQMASK`, `ADDR_EDGECAP`, `ADDR_EDGESEL`;
  - `AVL_DW = 32`.
- Sub-module `debounce_bit` contains the 2-FF synchronizer, the counter and `deb` for one bit, with parameter `DEBOUNCE_CYCLES`. The top instantiates it N_IN times in a generate loop.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Reset.** Assert `Reset` 2 cycles with `raw_in = 10'h3FF` → all four registers read 0 immediately after, `IRQ = 0`. `DATA` reads `10'h3FF` exactly 6 cycles after reset release, and `EDGECAP` stays 0.
- **Glitch rejection.** `raw_in[3]` high for 3 cycles, then low → `DATA[3]` never sets.
- **Valid rise.** `raw_in[3]` held high → `DATA[3] = 1` at edge k+6, and `EDGECAP` stays 0 (`EDGESEL = 0`).
- **Capture and interrupt.** Write `EDGESEL = 10'h200`, `IRQMASK = 10'h200`; drive `raw_in[9]` 0→1 → `EDGECAP = 10'h200` and `IRQ = 1` one cycle after `DATA[9]` rises. Write 2'b10 with `10'h200` → `IRQ = 0` the next cycle.
- **W1C/edge collision.** Issue the W1C of bit 8 on the same cycle as a new falling edge of `deb[8]` → `EDGECAP[8]` stays 1.
- **Read latency.** Back-to-back reads of addresses 0, 1, 2, 3 → each value appears exactly one cycle after its request, and `AVL_READDATA = 0` on idle cycles.
- **Reset mid-debounce.** Assert `Reset` at count 2 → `DATA` stays 0, and the full 6-cycle latency applies again after release.
